// File: rtl/pcs_tx_gearbox_if.sv
// rtl/pcs_tx_gearbox_if.sv - encoder-to-gearbox 66-bit block handshake
interface pcs_tx_gearbox_if;
  logic [63:0] i_block_data;
  logic [1:0]  i_block_hdr;
  logic        i_block_valid;
  logic        o_block_ready;

  // Encoder side drives blocks and observes backpressure.
  modport master (
    output i_block_data,
    output i_block_hdr,
    output i_block_valid,
    input  o_block_ready
  );

  // Gearbox side consumes blocks and drives backpressure.
  modport slave (
    input  i_block_data,
    input  i_block_hdr,
    input  i_block_valid,
    output o_block_ready
  );
endinterface

// File: rtl/pcs_tx_gearbox.sv
// rtl/pcs_tx_gearbox.sv - 64b/66b payload scrambler plus 66-to-32 bit TX gearbox

// Advances the x^58 + x^39 + 1 self-synchronous scrambler by 64 payload bits.
// state_i[0] is the most recently scrambled bit, state_i[57] the oldest.
module pcs_tx_scrambler58 (
  input  logic [57:0] state_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o,
  output logic [57:0] state_o
);
  logic [57:0] s;
  logic        sc_bit;

  // Unrolled bit-serial recurrence: sc[n] = d[n] ^ sc[n-39] ^ sc[n-58].
  always_comb begin
    s      = state_i;
    sc_bit = 1'b0;
    data_o = '0;
    for (int k = 0; k < 64; k++) begin
      sc_bit    = data_i[k] ^ s[38] ^ s[57];
      data_o[k] = sc_bit;
      s         = {s[56:0], sc_bit};
    end
    state_o = s;
  end
endmodule

module pcs_tx_gearbox #(
  parameter logic        SCRAMBLE_EN = 1'b1,
  parameter logic [57:0] SCR_SEED    = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  pcs_tx_gearbox_if.slave        blk_if,
  output logic [31:0]            o_tx_data,
  output logic                   o_tx_valid
);
  // 31 leftover bits plus one 66-bit block is the deepest the buffer gets.
  localparam int BUF_W = 98;

  logic [BUF_W-1:0] bits_q, bits_d;
  logic [6:0]       occ_q, occ_d;
  logic [57:0]      scr_q, scr_d;
  logic [31:0]      tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;

  logic             emit;
  logic             accept;
  logic [6:0]       base;
  logic [63:0]      pay_scr;
  logic [63:0]      pay_out;
  logic [57:0]      scr_next;
  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] keep_mask;
  logic [BUF_W-1:0] blk_ext;

  // Ready depends only on registered occupancy, so it is clean during reset.
  assign blk_if.o_block_ready = (occ_q < 7'd64);
  assign accept               = blk_if.i_block_valid & blk_if.o_block_ready;
  assign emit                 = (occ_q >= 7'd32);

  pcs_tx_scrambler58 u_scr (
    .state_i (scr_q),
    .data_i  (blk_if.i_block_data),
    .data_o  (pay_scr),
    .state_o (scr_next)
  );

  // Header always bypasses the scrambler; payload bypasses it when disabled.
  assign pay_out = SCRAMBLE_EN ? pay_scr : blk_if.i_block_data;

  // Next-state: drain one word if available, then append an accepted block at the new tail.
  always_comb begin
    shifted    = emit ? {32'b0, bits_q[BUF_W-1:32]} : bits_q;
    base       = emit ? (occ_q - 7'd32) : occ_q;
    // Bits above the tail are stale after shifting; clear them before OR-ing in the block.
    keep_mask  = ~({BUF_W{1'b1}} << base);
    blk_ext    = {32'b0, pay_out, blk_if.i_block_hdr} << base;
    bits_d     = shifted;
    occ_d      = base;
    scr_d      = scr_q;
    if (accept) begin
      bits_d = (shifted & keep_mask) | blk_ext;
      occ_d  = base + 7'd66;
      if (SCRAMBLE_EN) begin
        scr_d = scr_next;
      end
    end
    tx_valid_d = emit;
    tx_data_d  = emit ? bits_q[31:0] : tx_data_q;
  end

  // State registers with asynchronous reset that also reseeds the scrambler.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bits_q     <= '0;
      occ_q      <= '0;
      scr_q      <= SCR_SEED;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      bits_q     <= bits_d;
      occ_q      <= occ_d;
      scr_q      <= scr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
endmodule

// File: tb/tb_pcs_tx_gearbox.sv
// tb/tb_pcs_tx_gearbox.sv - scoreboard bench for pcs_tx_gearbox
module tb_pcs_tx_gearbox;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcs_tx_gearbox_if dut_if ();
  pcs_tx_gearbox_if byp_if ();

  logic [31:0] tx_data, byp_data;
  logic        tx_valid, byp_valid;

  pcs_tx_gearbox #(.SCRAMBLE_EN(1'b1), .SCR_SEED(58'h3FF_FFFF_FFFF_FFFF)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .blk_if(dut_if),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid)
  );

  pcs_tx_gearbox #(.SCRAMBLE_EN(1'b0), .SCR_SEED(58'h3FF_FFFF_FFFF_FFFF)) u_byp (
    .i_clk(clk), .i_reset_n(rst_n), .blk_if(byp_if),
    .o_tx_data(byp_data), .o_tx_valid(byp_valid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: bit-serial stream of {scrambled payload, hdr}, oldest first.
  bit          mq[$];
  logic [57:0] ms       = 58'h3FF_FFFF_FFFF_FFFF;
  int          prev_occ = 0;
  logic [31:0] cap_q[$];
  logic [31:0] byp_q[$];

  always @(negedge clk) begin : mon
    logic [31:0] exp_w;
    logic        x;
    if (!rst_n) begin
      mq.delete();
      ms       = 58'h3FF_FFFF_FFFF_FFFF;
      prev_occ = 0;
    end else begin
      check_val("tx_valid", 64'(tx_valid), 64'(prev_occ >= 32));
      if (tx_valid) begin
        if (mq.size() < 32) begin
          check_val("model_depth", 64'(mq.size()), 64'd32);
        end else begin
          exp_w = '0;
          for (int k = 0; k < 32; k++) exp_w[k] = mq.pop_front();
          check_val("tx_data", 64'(tx_data), 64'(exp_w));
        end
        cap_q.push_back(tx_data);
      end
      check_val("ready", 64'(dut_if.o_block_ready), 64'(mq.size() < 64));
      prev_occ = mq.size();
      if (dut_if.i_block_valid && dut_if.o_block_ready) begin
        mq.push_back(dut_if.i_block_hdr[0]);
        mq.push_back(dut_if.i_block_hdr[1]);
        for (int k = 0; k < 64; k++) begin
          x  = dut_if.i_block_data[k] ^ ms[19] ^ ms[0];
          ms = {x, ms[57:1]};
          mq.push_back(x);
        end
      end
    end
  end

  always @(negedge clk) begin : byp_mon
    if (rst_n && byp_valid) byp_q.push_back(byp_data);
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    dut_if.i_block_valid = 1'b0;
    byp_if.i_block_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_block(input logic [1:0] h, input logic [63:0] d);
    bit took;
    int n;
    dut_if.i_block_hdr   = h;
    dut_if.i_block_data  = d;
    dut_if.i_block_valid = 1'b1;
    took = 1'b0;
    n    = 0;
    while (!took && n < 50) begin
      @(negedge clk);
      took = dut_if.o_block_ready;
      @(posedge clk);
      #1;
      n++;
    end
    dut_if.i_block_valid = 1'b0;
    check_val("accepted", 64'(took), 64'd1);
  endtask

  task automatic run_stream(input int cycles, input int gap_at, input int gap_len,
                            output int accepts, output int low_valid, output int rdy_diff,
                            output int gap_drops);
    bit rdy_h[$];
    bit took;
    bit in_gap;
    accepts = 0; low_valid = 0; rdy_diff = 0; gap_drops = 0;
    for (int c = 0; c < cycles; c++) begin
      in_gap = (c >= gap_at) && (c < gap_at + gap_len);
      dut_if.i_block_valid = !in_gap;
      @(negedge clk);
      if (c >= 2 && !tx_valid) low_valid++;
      if (in_gap && !tx_valid) gap_drops++;
      rdy_h.push_back(dut_if.o_block_ready);
      if (c >= 33 && rdy_h[c] != rdy_h[c-33]) rdy_diff++;
      took = dut_if.i_block_valid && dut_if.o_block_ready;
      @(posedge clk);
      #1;
      if (took) begin
        accepts++;
        dut_if.i_block_hdr  = 2'($urandom_range(1, 2));
        dut_if.i_block_data = {$urandom, $urandom};
      end
    end
  endtask

  task automatic check_first_block(input string tag);
    cap_q.delete();
    send_block(2'b01, 64'h0);
    wait_cycles(6);
    check_val({tag, "_nwords"}, 64'(cap_q.size()), 64'd2);
    if (cap_q.size() >= 2) begin
      check_val({tag, "_w0"}, 64'(cap_q[0]), 64'h0000_0001);
      check_val({tag, "_w1"}, 64'(cap_q[1]), 64'h0FFF_FE00);
    end
  endtask

  int          acc, lowv, rdiff, gdrop;
  logic [63:0] bp;

  initial begin
    dut_if.i_block_valid = 1'b0; dut_if.i_block_hdr = '0; dut_if.i_block_data = '0;
    byp_if.i_block_valid = 1'b0; byp_if.i_block_hdr = '0; byp_if.i_block_data = '0;
    rst_n = 1'b0;
    #12;
    check_val("rst_tx_valid", 64'(tx_valid), 64'd0);
    check_val("rst_tx_data", 64'(tx_data), 64'd0);
    check_val("rst_ready", 64'(dut_if.o_block_ready), 64'd1);
    check_val("rst_byp_ready", 64'(byp_if.o_block_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    check_first_block("first_blk");

    bp = 64'h0123_4567_89AB_CDEF;
    byp_q.delete();
    byp_if.i_block_hdr   = 2'b10;
    byp_if.i_block_data  = bp;
    byp_if.i_block_valid = 1'b1;
    @(negedge clk);
    check_val("byp_ready", 64'(byp_if.o_block_ready), 64'd1);
    @(posedge clk);
    #1 byp_if.i_block_valid = 1'b0;
    wait_cycles(5);
    check_val("byp_nwords", 64'(byp_q.size()), 64'd2);
    if (byp_q.size() >= 2) begin
      check_val("byp_w0", 64'(byp_q[0]), 64'h26AF_37BE);
      check_val("byp_w1", 64'(byp_q[1]), 64'(bp[61:30]));
    end

    do_reset();
    dut_if.i_block_hdr  = 2'b01;
    dut_if.i_block_data = {$urandom, $urandom};
    run_stream(330, 1000, 0, acc, lowv, rdiff, gdrop);
    check_val("cont_accepts", 64'(acc), 64'd160);
    check_val("cont_valid_gaps", 64'(lowv), 64'd0);
    check_val("cont_ready_period", 64'(rdiff), 64'd0);

    run_stream(60, 20, 5, acc, lowv, rdiff, gdrop);
    check_val("starve_drop_seen", 64'(gdrop > 0), 64'd1);
    dut_if.i_block_valid = 1'b0;
    wait_cycles(8);
    check_val("drain_residue", 64'(mq.size() < 32), 64'd1);

    do_reset();
    dut_if.i_block_hdr   = 2'b01;
    dut_if.i_block_data  = 64'hDEAD_BEEF_0BAD_F00D;
    dut_if.i_block_valid = 1'b1;
    @(posedge clk);
    #1 dut_if.i_block_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val("pre_rst_valid", 64'(tx_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
    check_val("mid_rst_tx_data", 64'(tx_data), 64'd0);
    check_val("mid_rst_ready", 64'(dut_if.o_block_ready), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_first_block("post_rst_blk");

    do_reset();
    cap_q.delete();
    send_block(2'b00, {$urandom, $urandom});
    send_block(2'b11, {$urandom, $urandom});
    wait_cycles(8);
    check_val("badhdr_nwords", 64'(cap_q.size()), 64'd4);
    if (cap_q.size() >= 3) begin
      check_val("hdr00_bits", 64'(cap_q[0][1:0]), 64'd0);
      check_val("hdr11_bits", 64'(cap_q[2][3:2]), 64'd3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
